// File: rtl/passcode_checker_pkg.sv
// Shared types for the passcode checker: FSM state encoding and a key-vector decoder.
package passcode_checker_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        CHECK    = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam int unsigned KEY_VEC_MAX   = 32;
    localparam int unsigned KEY_IDX_MAX_W = 5;

    typedef struct packed {
        logic                     valid;
        logic [KEY_IDX_MAX_W-1:0] index;
    } key_decode_t;

    // valid only when exactly one bit is set; index is that bit's position
    function automatic key_decode_t onehot_to_index(input logic [KEY_VEC_MAX-1:0] vec);
        key_decode_t r;
        int unsigned hits;
        r    = '0;
        hits = 0;
        for (int unsigned i = 0; i < KEY_VEC_MAX; i++) begin
            if (vec[i]) begin
                hits++;
                r.index = KEY_IDX_MAX_W'(i);
            end
        end
        r.valid = (hits == 1);
        return r;
    endfunction

endpackage

// File: rtl/passcode_checker_if.sv
// Key-pulse input and lock-status outputs of the passcode checker.
interface passcode_checker_if #(
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned CODE_LENGTH = 4
);
    logic [NUM_KEYS-1:0]                  keyEdge;
    logic                                 locked;
    logic                                 error;
    logic                                 lockout;
    logic [$clog2(CODE_LENGTH+1)-1:0]     digitCount;

    modport master (
        output keyEdge,
        input  locked,
        input  error,
        input  lockout,
        input  digitCount
    );

    modport slave (
        input  keyEdge,
        output locked,
        output error,
        output lockout,
        output digitCount
    );
endinterface

// File: rtl/passcode_checker_lockout_timer.sv
// Loadable down-counter; done pulses for one cycle when the count reaches its last step.
module lockout_timer #(
    parameter int unsigned LOCKOUT_CYCLES = 50_000_000
) (
    input  logic reset,
    input  logic clock,
    input  logic start,
    output logic done
);
    localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= TW'(LOCKOUT_CYCLES);
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    // Loaded on the entry edge, so firing at 1 gives exactly LOCKOUT_CYCLES cycles in LOCKOUT
    assign done = (count == TW'(1));

endmodule

// File: rtl/passcode_checker.sv
// Digital-lock FSM: sets a passcode while unlocked, verifies it while locked, enforces lockout.
module passcode_checker
    import passcode_checker_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = 4,
    parameter int unsigned KEY_WIDTH      = 2,
    parameter int unsigned CODE_LENGTH    = 4,
    parameter logic [CODE_LENGTH*KEY_WIDTH-1:0] DEFAULT_CODE = '0,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned LOCKOUT_CYCLES = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    passcode_checker_if.slave bus
);
    localparam int unsigned CODE_W = CODE_LENGTH * KEY_WIDTH;
    localparam int unsigned CNT_W  = $clog2(CODE_LENGTH + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_ATTEMPTS + 1);

    state_t state, state_next;

    logic [CODE_W-1:0] stored_code;
    logic [CODE_W-1:0] digit_buf;
    logic [CODE_W-1:0] cmp_code;
    logic [CODE_W-1:0] buffer_next;
    logic [CNT_W-1:0]  digit_count;
    logic [FAIL_W-1:0] fail_count, fail_next;
    logic              error_q, error_next;
    logic              accept, complete;
    logic              timer_start, timer_done;

    logic [KEY_VEC_MAX-1:0] key_vec;
    key_decode_t            dec;

    assign key_vec     = KEY_VEC_MAX'(bus.keyEdge);
    assign dec         = onehot_to_index(key_vec);
    assign buffer_next = (digit_buf << KEY_WIDTH) | CODE_W'(dec.index);

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
        .reset (reset),
        .clock (clock),
        .start (timer_start),
        .done  (timer_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        complete    = 1'b0;
        timer_start = 1'b0;
        error_next  = 1'b0;
        fail_next   = fail_count;
        case (state)
            UNLOCKED, LOCKED: begin
                if (dec.valid) begin
                    accept = 1'b1;
                    if (digit_count == CNT_W'(CODE_LENGTH - 1)) begin
                        complete   = 1'b1;
                        state_next = (state == UNLOCKED) ? LOCKED : CHECK;
                    end
                end
            end
            CHECK: begin
                if (cmp_code == stored_code) begin
                    state_next = UNLOCKED;
                    fail_next  = '0;
                end else begin
                    error_next = 1'b1;
                    if (fail_count + FAIL_W'(1) == FAIL_W'(MAX_ATTEMPTS)) begin
                        state_next  = LOCKOUT;
                        fail_next   = '0;
                        timer_start = 1'b1;
                    end else begin
                        state_next = LOCKED;
                        fail_next  = fail_count + FAIL_W'(1);
                    end
                end
            end
            LOCKOUT: begin
                if (timer_done) begin
                    state_next = LOCKED;
                end
            end
            default: state_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stored_code <= DEFAULT_CODE;
            digit_buf   <= '0;
            cmp_code    <= '0;
            digit_count <= '0;
            fail_count  <= '0;
            error_q     <= 1'b0;
        end else begin
            error_q    <= error_next;
            fail_count <= fail_next;
            if (accept) begin
                digit_buf   <= buffer_next;
                digit_count <= complete ? '0 : digit_count + CNT_W'(1);
            end
            // The completing digit is taken from buffer_next, not the not-yet-updated buffer
            if (complete && state == UNLOCKED) begin
                stored_code <= buffer_next;
            end
            if (complete && state == LOCKED) begin
                cmp_code <= buffer_next;
            end
        end
    end

    assign bus.locked     = (state != UNLOCKED);
    assign bus.lockout    = (state == LOCKOUT);
    assign bus.error      = error_q;
    assign bus.digitCount = digit_count;

endmodule

// File: tb/tb_passcode_checker.sv
// Directed self-checking bench for passcode_checker (4 keys, 4 digits, 3 attempts, 8-cycle lockout).
module tb_passcode_checker;
    import passcode_checker_pkg::*;

    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    passcode_checker_if #(.NUM_KEYS(4), .CODE_LENGTH(4)) bus ();

    passcode_checker #(
        .NUM_KEYS       (4),
        .KEY_WIDTH      (2),
        .CODE_LENGTH    (4),
        .DEFAULT_CODE   (8'h00),
        .MAX_ATTEMPTS   (3),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle pulse sampled by the next rising edge; returns 1 ns after that edge
    task automatic press_raw(input logic [3:0] v);
        @(negedge clock);
        bus.keyEdge = v;
        @(posedge clock);
        #1;
        bus.keyEdge = '0;
    endtask

    task automatic press(input int k);
        logic [3:0] v;
        v = 4'b0001 << k;
        press_raw(v);
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
        press(d0);
        press(d1);
        press(d2);
        press(d3);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.keyEdge = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        compared++;
        if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
        compared++;
        if (bus.error !== 1'b0) begin mismatched++; $display("FAIL reset_error got=%b exp=0", bus.error); end
        compared++;
        if (bus.lockout !== 1'b0) begin mismatched++; $display("FAIL reset_lockout got=%b exp=0", bus.lockout); end
        compared++;
        if (bus.digitCount !== 3'd0) begin mismatched++; $display("FAIL reset_count got=%0d exp=0", bus.digitCount); end
    endtask

    task automatic test_set_code();
        int keys[4];
        keys = '{3, 1, 2, 0};
        for (int i = 0; i < 3; i++) begin
            press(keys[i]);
            compared++;
            if (bus.digitCount !== 3'(i + 1)) begin
                mismatched++; $display("FAIL set_count[%0d] got=%0d exp=%0d", i, bus.digitCount, i + 1);
            end
            compared++;
            if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL set_locked_early[%0d] got=%b exp=0", i, bus.locked); end
        end
        press(keys[3]);
        compared++;
        if (bus.digitCount !== 3'd0) begin mismatched++; $display("FAIL set_count_final got=%0d exp=0", bus.digitCount); end
        compared++;
        if (bus.locked !== 1'b1) begin mismatched++; $display("FAIL set_locked got=%b exp=1", bus.locked); end
        compared++;
        if (dut.stored_code !== 8'hD8) begin mismatched++; $display("FAIL set_code got=%h exp=d8", dut.stored_code); end
    endtask

    task automatic test_unlock();
        enter_code(3, 1, 2, 0);
        compared++;
        if (dut.state !== CHECK) begin mismatched++; $display("FAIL unlock_check_state got=%0d exp=%0d", dut.state, CHECK); end
        compared++;
        if (bus.locked !== 1'b1) begin mismatched++; $display("FAIL unlock_locked_in_check got=%b exp=1", bus.locked); end
        @(posedge clock);
        #1;
        compared++;
        if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL unlock_locked got=%b exp=0", bus.locked); end
        compared++;
        if (bus.error !== 1'b0) begin mismatched++; $display("FAIL unlock_error got=%b exp=0", bus.error); end
    endtask

    task automatic test_lockout();
        int lo_cycles;
        enter_code(3, 1, 2, 0);
        for (int a = 0; a < 3; a++) begin
            enter_code(0, 0, 0, 0);
            compared++;
            if (bus.error !== 1'b0) begin mismatched++; $display("FAIL lo_error_early[%0d] got=%b exp=0", a, bus.error); end
            @(posedge clock);
            #1;
            compared++;
            if (bus.error !== 1'b1) begin mismatched++; $display("FAIL lo_error_pulse[%0d] got=%b exp=1", a, bus.error); end
            compared++;
            if (bus.locked !== 1'b1) begin mismatched++; $display("FAIL lo_locked[%0d] got=%b exp=1", a, bus.locked); end
            compared++;
            if (bus.lockout !== (a == 2)) begin
                mismatched++; $display("FAIL lo_lockout_entry[%0d] got=%b exp=%b", a, bus.lockout, a == 2);
            end
            if (a < 2) begin
                @(posedge clock);
                #1;
                compared++;
                if (bus.error !== 1'b0) begin mismatched++; $display("FAIL lo_error_width[%0d] got=%b exp=0", a, bus.error); end
            end
        end
        lo_cycles = (bus.lockout === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20 && bus.lockout === 1'b1; i++) begin
            @(negedge clock);
            bus.keyEdge = 4'b0001 << (i % 4);
            @(posedge clock);
            #1;
            bus.keyEdge = '0;
            if (bus.lockout === 1'b1) lo_cycles++;
            if (i == 0) begin
                compared++;
                if (bus.error !== 1'b0) begin mismatched++; $display("FAIL lo_error_width_final got=%b exp=0", bus.error); end
            end
        end
        compared++;
        if (lo_cycles != 8) begin mismatched++; $display("FAIL lo_duration got=%0d exp=8", lo_cycles); end
        compared++;
        if (bus.locked !== 1'b1) begin mismatched++; $display("FAIL lo_exit_locked got=%b exp=1", bus.locked); end
        compared++;
        if (bus.lockout !== 1'b0) begin mismatched++; $display("FAIL lo_exit_lockout got=%b exp=0", bus.lockout); end
        compared++;
        if (bus.digitCount !== 3'd0) begin mismatched++; $display("FAIL lo_exit_count got=%0d exp=0", bus.digitCount); end
    endtask

    task automatic test_invalid_keys();
        press(3);
        compared++;
        if (bus.digitCount !== 3'd1) begin mismatched++; $display("FAIL inv_first got=%0d exp=1", bus.digitCount); end
        press_raw(4'b0011);
        compared++;
        if (bus.digitCount !== 3'd1) begin mismatched++; $display("FAIL inv_multi_count got=%0d exp=1", bus.digitCount); end
        compared++;
        if (bus.error !== 1'b0) begin mismatched++; $display("FAIL inv_multi_error got=%b exp=0", bus.error); end
        press_raw(4'b0000);
        compared++;
        if (bus.digitCount !== 3'd1) begin mismatched++; $display("FAIL inv_zero_count got=%0d exp=1", bus.digitCount); end
        press(1);
        press(2);
        compared++;
        if (bus.digitCount !== 3'd3) begin mismatched++; $display("FAIL inv_resume got=%0d exp=3", bus.digitCount); end
        press(0);
        @(posedge clock);
        #1;
        compared++;
        if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL inv_unlock got=%b exp=0", bus.locked); end
        compared++;
        if (bus.error !== 1'b0) begin mismatched++; $display("FAIL inv_unlock_error got=%b exp=0", bus.error); end
    endtask

    task automatic test_reset_mid_entry();
        enter_code(3, 1, 2, 0);
        press(1);
        press(2);
        compared++;
        if (bus.digitCount !== 3'd2) begin mismatched++; $display("FAIL rst_pre_count got=%0d exp=2", bus.digitCount); end
        #2;
        reset = 1'b0;
        #1;
        compared++;
        if (bus.digitCount !== 3'd0) begin mismatched++; $display("FAIL rst_async_count got=%0d exp=0", bus.digitCount); end
        compared++;
        if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL rst_async_locked got=%b exp=0", bus.locked); end
        compared++;
        if (dut.stored_code !== 8'h00) begin mismatched++; $display("FAIL rst_async_code got=%h exp=00", dut.stored_code); end
        @(negedge clock);
        reset = 1'b1;
        enter_code(0, 0, 0, 0);
        compared++;
        if (bus.locked !== 1'b1) begin mismatched++; $display("FAIL rst_relock got=%b exp=1", bus.locked); end
        enter_code(0, 0, 0, 0);
        @(posedge clock);
        #1;
        compared++;
        if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL rst_default_unlock got=%b exp=0", bus.locked); end
        compared++;
        if (bus.error !== 1'b0) begin mismatched++; $display("FAIL rst_default_error got=%b exp=0", bus.error); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        bus.keyEdge = '0;
        test_reset();
        test_set_code();
        test_unlock();
        test_lockout();
        test_invalid_keys();
        test_reset_mid_entry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
